// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the stopwatch/timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_TIMER     = 1'b1;

    localparam logic [7:0] DEF_MSB_MAX = 8'd99;
    localparam logic [7:0] DEF_LSB_MAX = 8'd59;

endpackage
`default_nettype wire

// File: rtl/timer_run_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_run_controller_if
// Description : Controller <-> counter datapath bus (enable, load, zero flag).
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_run_controller_if;

    logic       cnt_en;
    logic       cnt_load;
    logic [7:0] load_msb;
    logic [7:0] load_lsb;
    logic       mode;
    logic       cnt_zero;

    modport master (
        output cnt_en,
        output cnt_load,
        output load_msb,
        output load_lsb,
        output mode,
        input  cnt_zero
    );

    modport slave (
        input  cnt_en,
        input  cnt_load,
        input  load_msb,
        input  load_lsb,
        input  mode,
        output cnt_zero
    );

endinterface
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : One-cycle pulse on each rising edge of a level input.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic in,
    output logic      pulse
);

    logic r_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= in;
        end
    end

    assign pulse = in & ~r_in_q;

endmodule
`default_nettype wire

// File: rtl/timer_run_controller.sv
`default_nettype none
// ============================================================================
// Module      : timer_run_controller
// Description : Run/pause/expiry sequencer, preset owner and alarm generator
//               for the two-mode stopwatch/timer counter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_run_controller
    import timer_pkg::*;
#(
    parameter logic [7:0]  PRESET_MSB_DEF = 8'd2,
    parameter logic [7:0]  PRESET_LSB_DEF = 8'd0,
    parameter logic [7:0]  MSB_MAX        = DEF_MSB_MAX,
    parameter logic [7:0]  LSB_MAX        = DEF_LSB_MAX,
    parameter int unsigned ALARM_TICKS    = 5
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     tick,
    input  wire logic                     start_stop,
    input  wire logic                     clear,
    input  wire logic                     mode_sel,
    input  wire logic                     inc_msb,
    input  wire logic                     inc_lsb,
    timer_run_controller_if.master        dp,
    output logic [1:0]                    state_o,
    output logic                          alarm
);

    localparam int unsigned            c_alarm_w   = $clog2(ALARM_TICKS + 1);
    localparam logic [c_alarm_w-1:0]   c_alarm_max = c_alarm_w'(ALARM_TICKS);

    logic w_start_rise;
    logic w_clear_rise;
    logic w_inc_msb_rise;
    logic w_inc_lsb_rise;

    rise_detect u_rd_start (.clk(clk), .rst(rst), .in(start_stop), .pulse(w_start_rise));
    rise_detect u_rd_clear (.clk(clk), .rst(rst), .in(clear),      .pulse(w_clear_rise));
    rise_detect u_rd_inc_m (.clk(clk), .rst(rst), .in(inc_msb),    .pulse(w_inc_msb_rise));
    rise_detect u_rd_inc_l (.clk(clk), .rst(rst), .in(inc_lsb),    .pulse(w_inc_lsb_rise));

    state_t               r_state,     w_state_nxt;
    logic                 r_mode,      w_mode_nxt;
    logic [7:0]           r_pre_msb,   w_pre_msb_nxt;
    logic [7:0]           r_pre_lsb,   w_pre_lsb_nxt;
    logic                 r_load_pend, w_load_pend_nxt;
    logic                 r_alarm,     w_alarm_nxt;
    logic [c_alarm_w-1:0] r_alarm_cnt, w_alarm_cnt_nxt;

    logic w_preset_zero;
    logic w_expire;

    assign w_preset_zero = (r_pre_msb == 8'd0) && (r_pre_lsb == 8'd0);
    assign w_expire      = (r_mode == MODE_TIMER) && dp.cnt_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_STOPWATCH;
            r_pre_msb   <= PRESET_MSB_DEF;
            r_pre_lsb   <= PRESET_LSB_DEF;
            r_load_pend <= 1'b1;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_pre_msb   <= w_pre_msb_nxt;
            r_pre_lsb   <= w_pre_lsb_nxt;
            r_load_pend <= w_load_pend_nxt;
            r_alarm     <= w_alarm_nxt;
            r_alarm_cnt <= w_alarm_cnt_nxt;
        end
    end

    // Event priority: clear, then expiry, then start/stop, then preset increments.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_nxt      = r_mode;
        w_pre_msb_nxt   = r_pre_msb;
        w_pre_lsb_nxt   = r_pre_lsb;
        w_load_pend_nxt = 1'b0;
        w_alarm_nxt     = r_alarm;
        w_alarm_cnt_nxt = r_alarm_cnt;

        if ((r_state == IDLE) && (mode_sel != r_mode)) begin
            w_mode_nxt      = mode_sel;
            w_load_pend_nxt = 1'b1;
        end

        if (w_clear_rise) begin
            w_state_nxt     = IDLE;
            w_alarm_nxt     = 1'b0;
            w_load_pend_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_rise) begin
                        if (!((r_mode == MODE_TIMER) && w_preset_zero)) begin
                            w_state_nxt = RUN;
                        end
                    end else if (r_mode == MODE_TIMER) begin
                        if (w_inc_msb_rise) begin
                            w_pre_msb_nxt = (r_pre_msb == MSB_MAX) ? 8'd0 : r_pre_msb + 8'd1;
                        end
                        if (w_inc_lsb_rise) begin
                            w_pre_lsb_nxt = (r_pre_lsb == LSB_MAX) ? 8'd0 : r_pre_lsb + 8'd1;
                        end
                        if (w_inc_msb_rise || w_inc_lsb_rise) begin
                            w_load_pend_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_expire) begin
                        w_state_nxt     = EXPIRED;
                        w_alarm_nxt     = 1'b1;
                        w_alarm_cnt_nxt = '0;
                    end else if (w_start_rise) begin
                        w_state_nxt = PAUSE;
                    end
                end
                PAUSE: begin
                    if (w_start_rise) begin
                        w_state_nxt = RUN;
                    end
                end
                EXPIRED: begin
                    if (w_start_rise) begin
                        w_state_nxt     = IDLE;
                        w_alarm_nxt     = 1'b0;
                        w_load_pend_nxt = 1'b1;
                    end else if (tick && (r_alarm_cnt != c_alarm_max)) begin
                        w_alarm_cnt_nxt = r_alarm_cnt + 1'b1;
                        if ((r_alarm_cnt + 1'b1) == c_alarm_max) begin
                            w_alarm_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Zero-latency enable; a timer sitting at 00:00 is never clocked below zero.
    assign dp.cnt_en   = (r_state == RUN) & tick & ~(r_mode & dp.cnt_zero);
    assign dp.cnt_load = r_load_pend;
    assign dp.load_msb = (r_mode == MODE_TIMER) ? r_pre_msb : 8'd0;
    assign dp.load_lsb = (r_mode == MODE_TIMER) ? r_pre_lsb : 8'd0;
    assign dp.mode     = r_mode;

    assign state_o = r_state;
    assign alarm   = r_alarm;

endmodule
`default_nettype wire
